joypad_poller: RTL and testbench
================================

Name: joypad_poller

Overview:
- Sits between the CPU peripheral bus and nes_bridge.
- Periodically or on demand pulses the bridge's start, waits for a valid sample, then captures the 8-bit joypad byte.
- Derives sticky pressed/released edge flags and exposes them as four byte-wide CPU registers.
- Owns the bridge's rdata_addr select, so the CPU never drives the bridge directly.

Parameters:
- POLL_PERIOD, 833333, clk cycles between automatic polls (60 Hz at 50 MHz); must be >= 2.
- TIMEOUT_CYCLES, 2000000, max cycles spent waiting for a valid sample before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bus_sel  in  1  register access strobe, one cycle
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  2  register index
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, registered, valid the cycle after bus_sel
- bridge_start  out  1  start pulse to nes_bridge
- bridge_addr  out  2  rdata_addr select to nes_bridge
- bridge_rdata  in  8  nes_bridge rdata, combinational on bridge_addr

Behaviour:
- Reset: synchronous, active-high, single clk domain. Drives the following values:
  - bridge_start = 0, bridge_addr = 2'b00, bus_rdata = 0.
  - All registers 0, poll counter 0, state S_IDLE.
- Registers (bus_addr):
  - 0 CTRL (rw): bit0 AUTO enables periodic polling. Writing bit1 = 1 requests one poll (self-clearing, reads 0). bits7:2 read 0.
  - 1 STATUS (r, w1c): bit0 BUSY (state != S_IDLE, read-only), bit1 NEW (sample captured since last clear), bit2 TIMEOUT (sticky). Writing 1 to bit1 or bit2 clears that bit.
  - 2 BUTTONS (r): last captured joypad byte. Writes are ignored.
  - 3 EDGES (r, w1c): bits3:0 = pressed flags for joypad[3:0]; bits7:4 = pressed flags for joypad[7:4]. The field means pressed = cur & ~prev, ORed sticky. Writing 1 to a bit clears it.
- Poll counter:
  - Counts 0..POLL_PERIOD-1 while AUTO = 1, and holds at 0 while AUTO = 0.
  - Wrap raises a poll request. A one-shot request is ORed in.
  - The request is pending until consumed by the S_IDLE -> S_KICK transition. Requests arriving while BUSY are dropped, not queued.
- FSM:
  - S_IDLE: bridge_addr = 00. Pending request -> S_KICK.
  - S_KICK: bridge_addr = 00. When bridge_rdata[0] (ready) = 1, assert bridge_start for exactly that cycle, clear the timeout counter -> S_WAIT.
  - S_WAIT: bridge_addr = 01. The timeout counter increments each cycle.
    - bridge_rdata[0] (joypad_valid) = 1 -> S_CAPTURE.
    - Counter reaches TIMEOUT_CYCLES - 1 -> set TIMEOUT, -> S_IDLE.
  - S_CAPTURE: bridge_addr = 10. In one cycle, prev <= BUTTONS, BUTTONS <= bridge_rdata, EDGES |= bridge_rdata & ~BUTTONS, NEW <= 1 -> S_IDLE.
- Latency: the bridge's valid is registered and clears on the cycle after start, so S_WAIT never sees stale valid from the previous poll. From start accepted to BUTTONS update = bridge transaction time + 2 cycles.
- Simultaneous events:
  - A w1c clear of EDGES/NEW in the same cycle as S_CAPTURE: set wins for bits set by the capture; other bits clear.
  - A CTRL write with AUTO = 0 during a poll does not abort it.
- Bus reads return the register value before same-cycle updates.
- Reset mid-poll returns to S_IDLE with outputs at reset values. The bridge may still be mid-transaction; S_KICK waits on ready before issuing the next start.

Optional Feature:
- Macro: JOYPAD_POLLER_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, registered, reset 0) and CTRL bit2 IRQ_EN.
  - irq = IRQ_EN & (|EDGES | TIMEOUT), level-sensitive; cleared via the w1c bits.
- When undefined: no irq port, CTRL bit2 reads 0 and is not writable.

Decomposition:
- Package joypad_pkg holds:
  - register offsets (REG_CTRL = 0, REG_STATUS = 1, REG_BUTTONS = 2, REG_EDGES = 3);
  - bridge select constants (BR_READY = 2'b00, BR_VALID = 2'b01, BR_JOYPAD = 2'b10);
  - FSM state encodings (S_IDLE, S_KICK, S_WAIT, S_CAPTURE);
  - CTRL/STATUS bit indices;
  - button bit indices matching the bridge's joypad byte.
- One sub-module: poll_tick_gen (parameter PERIOD, inputs clk/rst/en, output one-cycle tick).

Test Plan:
- One-shot: write CTRL = 0x02; the bridge model returns joypad 0x81 after 500 cycles. Require:
  - exactly one bridge_start pulse;
  - then BUTTONS = 0x81, STATUS = 0x02, EDGES = 0x81.
- Edges: after BUTTONS = 0x81, poll with 0x83 -> EDGES = 0x83. Write EDGES = 0x83 -> reads 0x00. Poll with 0x01 -> EDGES stays 0x00.
- Auto: POLL_PERIOD = 100, CTRL = 0x01, bridge responds in 20 cycles. Require bridge_start pulses 100 cycles apart, 5 captures in 520 cycles.
- Timeout: TIMEOUT_CYCLES = 50, bridge never asserts valid. Require STATUS bit2 = 1 at cycle ~51 after start, FSM back to S_IDLE. Write STATUS = 0x04 -> bit2 = 0.
- Busy bridge: hold ready = 0 for 30 cycles after a request. Require bridge_start = 0 throughout, then one pulse on the first ready = 1 cycle.
- Reset mid-S_WAIT: assert rst one cycle. Require all registers 0, bridge_start = 0, bridge_addr = 00, and a subsequent one-shot completes normally.

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared constants for joypad_poller: register map, bridge selects, FSM states
// and bit positions within the CTRL/STATUS registers and the joypad byte.
package joypad_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BUTTONS = 2'd2;
  localparam logic [1:0] REG_EDGES   = 2'd3;

  localparam logic [1:0] BR_READY  = 2'b00;
  localparam logic [1:0] BR_VALID  = 2'b01;
  localparam logic [1:0] BR_JOYPAD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KICK    = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam int CTRL_AUTO    = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_NEW     = 1;
  localparam int STAT_TIMEOUT = 2;

  // Bit order of the bridge's joypad byte (standard NES shift order).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running poll period counter: counts 0..PERIOD-1 while en is high,
// holds at 0 otherwise, and emits a one-cycle tick on the wrap cycle.
module poll_tick_gen #(
  parameter int PERIOD = 833333
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (en) begin
      if (cnt_q == LAST) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/joypad_poller.sv
// CPU-facing poller for nes_bridge: kicks a sample, waits for valid, captures
// the joypad byte and keeps sticky press flags. Optional irq: JOYPAD_POLLER_IRQ_EN.
module joypad_poller
  import joypad_pkg::*;
#(
  parameter int POLL_PERIOD    = 833333,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bridge_start,
  output logic [1:0] bridge_addr,
  input  logic [7:0] bridge_rdata
`ifdef JOYPAD_POLLER_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          auto_q, auto_d;
  logic          new_q, new_d;
  logic          timeout_q, timeout_d;
  logic          req_q, req_d;
  logic [7:0]    buttons_q, buttons_d;
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    edges_q, edges_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    bus_rdata_q, bus_rdata_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic          poll_tick;
  logic          oneshot;
  logic          busy;
  logic [7:0]    ctrl_val;
  logic [7:0]    status_val;

  poll_tick_gen #(.PERIOD(POLL_PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (auto_q),
    .tick (poll_tick)
  );

  assign busy      = (state_q != S_IDLE);
  assign bus_rdata = bus_rdata_q;

  always_comb begin
    state_d      = state_q;
    auto_d       = auto_q;
    new_d        = new_q;
    timeout_d    = timeout_q;
    req_d        = 1'b0;
    buttons_d    = buttons_q;
    prev_d       = prev_q;
    edges_d      = edges_q;
    tcnt_d       = tcnt_q;
    bus_rdata_d  = bus_rdata_q;
    irq_en_d     = irq_en_q;
    oneshot      = 1'b0;
    bridge_start = 1'b0;
    bridge_addr  = BR_READY;

`ifdef JOYPAD_POLLER_IRQ_EN
    ctrl_val = {5'b0, irq_en_q, 1'b0, auto_q};
`else
    ctrl_val = {7'b0, auto_q};
`endif
    status_val = {5'b0, timeout_q, new_q, busy};

    // Reads see pre-update values; writes are applied before FSM sets so set wins.
    if (bus_sel && !bus_we) begin
      case (bus_addr)
        REG_CTRL:    bus_rdata_d = ctrl_val;
        REG_STATUS:  bus_rdata_d = status_val;
        REG_BUTTONS: bus_rdata_d = buttons_q;
        default:     bus_rdata_d = edges_q;
      endcase
    end

    if (bus_sel && bus_we) begin
      case (bus_addr)
        REG_CTRL: begin
          auto_d  = bus_wdata[CTRL_AUTO];
          oneshot = bus_wdata[CTRL_ONESHOT];
`ifdef JOYPAD_POLLER_IRQ_EN
          irq_en_d = bus_wdata[CTRL_IRQ_EN];
`endif
        end
        REG_STATUS: begin
          if (bus_wdata[STAT_NEW])     new_d     = 1'b0;
          if (bus_wdata[STAT_TIMEOUT]) timeout_d = 1'b0;
        end
        REG_EDGES: edges_d = edges_q & ~bus_wdata;
        default: ;
      endcase
    end

    // A pending request is consumed by leaving S_IDLE; anything arriving while busy is lost.
    if (state_q == S_IDLE && !req_q) begin
      req_d = poll_tick | oneshot;
    end

    case (state_q)
      S_IDLE: begin
        if (req_q) state_d = S_KICK;
      end
      S_KICK: begin
        if (bridge_rdata[0]) begin
          bridge_start = 1'b1;
          tcnt_d       = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        bridge_addr = BR_VALID;
        if (bridge_rdata[0]) begin
          state_d = S_CAPTURE;
        end else if (tcnt_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        bridge_addr = BR_JOYPAD;
        prev_d      = buttons_q;
        buttons_d   = bridge_rdata;
        edges_d     = edges_d | (bridge_rdata & ~buttons_q);
        new_d       = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = irq_en_q & ((|edges_q) | timeout_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      auto_q      <= 1'b0;
      new_q       <= 1'b0;
      timeout_q   <= 1'b0;
      req_q       <= 1'b0;
      buttons_q   <= '0;
      prev_q      <= '0;
      edges_q     <= '0;
      tcnt_q      <= '0;
      bus_rdata_q <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      auto_q      <= auto_d;
      new_q       <= new_d;
      timeout_q   <= timeout_d;
      req_q       <= req_d;
      buttons_q   <= buttons_d;
      prev_q      <= prev_d;
      edges_q     <= edges_d;
      tcnt_q      <= tcnt_d;
      bus_rdata_q <= bus_rdata_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

`ifdef JOYPAD_POLLER_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a behavioural nes_bridge model; a second
// instance with a short timeout and a bridge that never reports valid.
module tb_joypad_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       bridge_start;
  logic [1:0] bridge_addr;
  logic [7:0] bridge_rdata;

  logic       t_sel = 1'b0, t_we = 1'b0;
  logic [1:0] t_addr = 2'd0;
  logic [7:0] t_wdata = 8'h00;
  logic [7:0] t_rdata;
  logic       t_start;
  logic [1:0] t_baddr;
  logic [7:0] t_brdata;
`ifdef JOYPAD_POLLER_IRQ_EN
  logic       irq, t_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  joypad_poller #(.POLL_PERIOD(100), .TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_sel      (sel),
    .bus_we       (we),
    .bus_addr     (addr),
    .bus_wdata    (wdata),
    .bus_rdata    (rdata),
    .bridge_start (bridge_start),
    .bridge_addr  (bridge_addr),
    .bridge_rdata (bridge_rdata)
`ifdef JOYPAD_POLLER_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  joypad_poller #(.POLL_PERIOD(100), .TIMEOUT_CYCLES(50)) dut_t (
    .clk          (clk),
    .rst          (rst),
    .bus_sel      (t_sel),
    .bus_we       (t_we),
    .bus_addr     (t_addr),
    .bus_wdata    (t_wdata),
    .bus_rdata    (t_rdata),
    .bridge_start (t_start),
    .bridge_addr  (t_baddr),
    .bridge_rdata (t_brdata)
`ifdef JOYPAD_POLLER_IRQ_EN
    ,
    .irq          (t_irq)
`endif
  );

  // Bridge model: ready/valid registered, valid drops the cycle after start.
  logic       br_ready = 1'b1;
  logic       br_valid = 1'b0;
  logic [7:0] br_joy   = 8'h00;
  int         br_cnt   = 0;
  int         br_delay = 20;
  logic [7:0] br_next  = 8'h00;
  logic       br_hold  = 1'b0;

  always @(posedge clk) begin
    if (bridge_start) begin
      br_ready <= 1'b0;
      br_valid <= 1'b0;
      br_cnt   <= br_delay;
    end else if (!br_ready) begin
      if (br_cnt > 0) begin
        br_cnt <= br_cnt - 1;
      end else begin
        br_ready <= 1'b1;
        br_valid <= 1'b1;
        br_joy   <= br_next;
      end
    end
  end

  always_comb begin
    case (bridge_addr)
      2'b00:   bridge_rdata = {7'b0, br_ready & ~br_hold};
      2'b01:   bridge_rdata = {7'b0, br_valid};
      2'b10:   bridge_rdata = br_joy;
      default: bridge_rdata = 8'h00;
    endcase
  end

  assign t_brdata = (t_baddr == 2'b00) ? 8'h01 : 8'h00;

  int cyc = 0, start_cnt = 0, cap_cnt = 0, t_start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bridge_start)         start_cnt   <= start_cnt + 1;
    if (bridge_addr == 2'b10) cap_cnt     <= cap_cnt + 1;
    if (t_start)              t_start_cnt <= t_start_cnt + 1;
  end

  task automatic bus_write(input bit t, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    if (t) begin t_sel = 1'b1; t_we = 1'b1; t_addr = a; t_wdata = d; end
    else   begin sel   = 1'b1; we   = 1'b1; addr   = a; wdata   = d; end
    @(negedge clk);
    sel = 1'b0; we = 1'b0; t_sel = 1'b0; t_we = 1'b0;
  endtask

  task automatic bus_read(input bit t, input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    if (t) begin t_sel = 1'b1; t_we = 1'b0; t_addr = a; end
    else   begin sel   = 1'b1; we   = 1'b0; addr   = a; end
    @(negedge clk);
    sel = 1'b0; t_sel = 1'b0;
    d = t ? t_rdata : rdata;
  endtask

  task automatic wait_idle(input bit t, input int budget, output bit ok);
    logic [7:0] s;
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(t, 2'd1, s);
      if (s[0] == 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bridge_start !== 1'b0) $display("FAIL reset_start: got %b want 0", bridge_start);
    else n_pass++;
    n_checks++;
    if (bridge_addr !== 2'b00) $display("FAIL reset_baddr: got %b want 00", bridge_addr);
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b0, i[1:0], v);
      n_checks++;
      if (v !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", i, v);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] v;
    bit ok;
    int s0;
    br_delay = 500;
    br_next  = 8'h81;
    s0 = start_cnt;
    bus_write(1'b0, 2'd0, 8'h02);
    wait_idle(1'b0, 2000, ok);
    n_checks++;
    if (!ok) $display("FAIL oneshot_done: got busy want idle");
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 !== 1) $display("FAIL oneshot_starts: got %0d want 1", start_cnt - s0);
    else n_pass++;
    bus_read(1'b0, 2'd2, v);
    n_checks++;
    if (v !== 8'h81) $display("FAIL oneshot_buttons: got %h want 81", v);
    else n_pass++;
    bus_read(1'b0, 2'd1, v);
    n_checks++;
    if (v !== 8'h02) $display("FAIL oneshot_status: got %h want 02", v);
    else n_pass++;
    bus_read(1'b0, 2'd3, v);
    n_checks++;
    if (v !== 8'h81) $display("FAIL oneshot_edges: got %h want 81", v);
    else n_pass++;
    bus_read(1'b0, 2'd0, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL oneshot_ctrl_selfclear: got %h want 00", v);
    else n_pass++;
  endtask

  task automatic test_edges();
    logic [7:0] v;
    bit ok;
    br_delay = 20;
    br_next  = 8'h83;
    bus_write(1'b0, 2'd0, 8'h02);
    wait_idle(1'b0, 500, ok);
    bus_read(1'b0, 2'd3, v);
    n_checks++;
    if (v !== 8'h83) $display("FAIL edges_press: got %h want 83", v);
    else n_pass++;
    bus_write(1'b0, 2'd3, 8'h83);
    bus_read(1'b0, 2'd3, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL edges_w1c: got %h want 00", v);
    else n_pass++;
    bus_write(1'b0, 2'd1, 8'h02);
    bus_read(1'b0, 2'd1, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL status_new_w1c: got %h want 00", v);
    else n_pass++;
    br_next = 8'h01;
    bus_write(1'b0, 2'd0, 8'h02);
    wait_idle(1'b0, 500, ok);
    bus_read(1'b0, 2'd3, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL edges_release: got %h want 00", v);
    else n_pass++;
    bus_read(1'b0, 2'd2, v);
    n_checks++;
    if (v !== 8'h01) $display("FAIL edges_buttons: got %h want 01", v);
    else n_pass++;
  endtask

  task automatic test_busy_bridge();
    logic [7:0] v;
    bit ok, saw;
    int s0;
    br_hold = 1'b1;
    s0 = start_cnt;
    saw = 1'b0;
    bus_write(1'b0, 2'd0, 8'h02);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bridge_start !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw || start_cnt != s0) $display("FAIL busy_no_start: got %0d starts want 0", start_cnt - s0);
    else n_pass++;
    bus_read(1'b0, 2'd1, v);
    n_checks++;
    if (v[0] !== 1'b1) $display("FAIL busy_flag: got %b want 1", v[0]);
    else n_pass++;
    br_hold = 1'b0;
    @(negedge clk);
    n_checks++;
    if (start_cnt - s0 !== 1) $display("FAIL busy_first_ready: got %0d starts want 1", start_cnt - s0);
    else n_pass++;
    n_checks++;
    if (bridge_addr !== 2'b01) $display("FAIL busy_wait_addr: got %b want 01", bridge_addr);
    else n_pass++;
    wait_idle(1'b0, 500, ok);
    n_checks++;
    if (!ok) $display("FAIL busy_done: got busy want idle");
    else n_pass++;
  endtask

  task automatic test_auto();
    bit ok, got;
    int s0, c0, cap0, prev;
    br_delay = 20;
    br_next  = 8'h10;
    s0 = start_cnt;
    bus_write(1'b0, 2'd0, 8'h01);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (start_cnt != s0) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL auto_first_start: got none want one within 300 cycles");
    else n_pass++;
    c0 = cyc;
    cap0 = cap_cnt;
    prev = c0;
    for (int k = 1; k <= 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (start_cnt >= s0 + 1 + k) got = 1'b1;
      end
      n_checks++;
      if (cyc - prev !== 100) $display("FAIL auto_period%0d: got %0d want 100", k, cyc - prev);
      else n_pass++;
      prev = cyc;
    end
    while (cyc < c0 + 520) @(negedge clk);
    n_checks++;
    if (cap_cnt - cap0 !== 5) $display("FAIL auto_captures: got %0d want 5", cap_cnt - cap0);
    else n_pass++;
    bus_write(1'b0, 2'd0, 8'h00);
    wait_idle(1'b0, 500, ok);
    n_checks++;
    if (!ok) $display("FAIL auto_stop: got busy want idle");
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    bit got;
    int s0;
    s0 = t_start_cnt;
    bus_write(1'b1, 2'd0, 8'h02);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t_start_cnt != s0) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL timeout_start: got none want one");
    else n_pass++;
    repeat (49) @(negedge clk);
    n_checks++;
    if (t_baddr !== 2'b01) $display("FAIL timeout_still_wait: got %b want 01", t_baddr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (t_baddr !== 2'b00) $display("FAIL timeout_back_idle: got %b want 00", t_baddr);
    else n_pass++;
    bus_read(1'b1, 2'd1, v);
    n_checks++;
    if (v !== 8'h04) $display("FAIL timeout_status: got %h want 04", v);
    else n_pass++;
    bus_write(1'b1, 2'd1, 8'h04);
    bus_read(1'b1, 2'd1, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL timeout_w1c: got %h want 00", v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] v;
    bit ok;
    br_delay = 200;
    br_next  = 8'h42;
    bus_write(1'b0, 2'd0, 8'h02);
    repeat (20) @(negedge clk);
    n_checks++;
    if (bridge_addr !== 2'b01) $display("FAIL rstmid_in_wait: got %b want 01", bridge_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bridge_start !== 1'b0 || bridge_addr !== 2'b00 || rdata !== 8'h00)
      $display("FAIL rstmid_outputs: got start=%b addr=%b rdata=%h want 0/00/00", bridge_start, bridge_addr, rdata);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b0, i[1:0], v);
      n_checks++;
      if (v !== 8'h00) $display("FAIL rstmid_reg%0d: got %h want 00", i, v);
      else n_pass++;
    end
    br_delay = 30;
    bus_write(1'b0, 2'd0, 8'h02);
    wait_idle(1'b0, 1000, ok);
    n_checks++;
    if (!ok) $display("FAIL rstmid_done: got busy want idle");
    else n_pass++;
    bus_read(1'b0, 2'd2, v);
    n_checks++;
    if (v !== 8'h42) $display("FAIL rstmid_buttons: got %h want 42", v);
    else n_pass++;
    bus_read(1'b0, 2'd3, v);
    n_checks++;
    if (v !== 8'h42) $display("FAIL rstmid_edges: got %h want 42", v);
    else n_pass++;
    bus_read(1'b0, 2'd1, v);
    n_checks++;
    if (v !== 8'h02) $display("FAIL rstmid_status: got %h want 02", v);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_edges();
    test_busy_bridge();
    test_auto();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
